// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2, K=3 hard-decision Viterbi decoder:
// generator polynomials, trellis/symbol widths, FSM states and the
// expected-symbol / Hamming-distance helpers used by the ACS units.
package viterbi_pkg;

  localparam logic [2:0] G1    = 3'b111;
  localparam logic [2:0] G2    = 3'b101;
  localparam int         SW    = 2;
  localparam int         SYM_W = 2;

  typedef logic [SW-1:0]    state_t;
  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    TRACE = 2'd1,
    OUT   = 2'd2
  } fsm_t;

  // Encoder output when input bit b is shifted into state st = {p1, p2}.
  function automatic sym_t exp_sym(input state_t st, input logic b);
    logic [2:0] shift_s;
    shift_s = {b, st};
    return {^(shift_s & G1), ^(shift_s & G2)};
  endfunction

  // Number of differing bits between two code symbols (0..2).
  function automatic logic [1:0] hamming(input sym_t a, input sym_t b);
    sym_t diff_s;
    diff_s = a ^ b;
    return {1'b0, diff_s[1]} + {1'b0, diff_s[0]};
  endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// Symbol-in / bit-out stream interface of the Viterbi decoder.
// slave: decoder side, master: source/sink side.
interface viterbi_decoder_if;
  import viterbi_pkg::*;

  logic i_valid;
  sym_t i_data;
  logic i_last;
  logic o_ready;
  logic o_valid;
  logic o_data;
  logic o_last;
  logic i_ready;

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last
  );

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last
  );

endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis next state {b, p1}. The two
// predecessors are {p1, 0} and {p1, 1}; ties resolve to p2 = 0 and the
// decision bit is the chosen p2.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int     PM_W       = 8,
  parameter state_t NEXT_STATE = 2'b00
) (
  input  sym_t            sym,
  input  logic [PM_W-1:0] pm_from0,
  input  logic [PM_W-1:0] pm_from1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  localparam logic   IN_BIT = NEXT_STATE[1];
  localparam state_t PREV0  = {NEXT_STATE[0], 1'b0};
  localparam state_t PREV1  = {NEXT_STATE[0], 1'b1};

  logic [PM_W-1:0] cand0_s;
  logic [PM_W-1:0] cand1_s;

  // Accumulate branch metrics and keep the cheaper predecessor.
  always_comb begin
    cand0_s = pm_from0 + PM_W'(hamming(sym, exp_sym(PREV0, IN_BIT)));
    cand1_s = pm_from1 + PM_W'(hamming(sym, exp_sym(PREV1, IN_BIT)));
    if (cand1_s < cand0_s) begin
      pm_new = cand1_s;
      dec    = 1'b1;
    end else begin
      pm_new = cand0_s;
      dec    = 1'b0;
    end
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder (G1=111, G2=101). Receives up to MAX_LEN
// symbols, traces back through the survivor RAM one step per cycle, then
// streams the decoded bits in original order.
// Optional build macro VITERBI_TAIL_EN: frame ends in two zero tail bits,
// traceback starts at state 0 and the tail bits are not output.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int PM_W    = 8
) (
  input logic i_clk,
  input logic i_rst,
  viterbi_decoder_if.slave bus
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [PM_W-1:0]  PM_INIT  = {2'b01, {(PM_W-2){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

  fsm_t             state_r, state_n;
  logic [PM_W-1:0]  pm_r      [4];
  logic [PM_W-1:0]  pm_acs_s  [4];
  logic [PM_W-1:0]  pm_norm_s [4];
  logic [3:0]       dec_s;
  logic             norm_s;
  logic [3:0]       surv_r    [MAX_LEN];
  logic             out_buf_r [MAX_LEN];
  logic [CNT_W-1:0] count_r, n_s, out_cnt_s, out_cnt_r;
  logic [IDX_W-1:0] k_r, j_r;
  state_t           tb_state_r, start_s;
  logic             o_ready_r, o_valid_r, o_data_r, o_last_r;
  logic             accept_s, frame_end_s, trace_done_s, out_hs_s, last_hs_s;

  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam state_t NS = state_t'(g);
    viterbi_acs #(.PM_W(PM_W), .NEXT_STATE(NS)) u_acs (
      .sym      (bus.i_data),
      .pm_from0 (pm_r[{NS[0], 1'b0}]),
      .pm_from1 (pm_r[{NS[0], 1'b1}]),
      .pm_new   (pm_acs_s[g]),
      .dec      (dec_s[g])
    );
  end

  assign accept_s     = (state_r == RECV) && bus.i_valid;
  assign frame_end_s  = accept_s && (bus.i_last || (count_r == LAST_IDX));
  assign trace_done_s = (state_r == TRACE) && (k_r == '0);
  assign out_hs_s     = (state_r == OUT) && o_valid_r && bus.i_ready;
  assign last_hs_s    = out_hs_s && ((CNT_W'(j_r) + CNT_W'(1)) == out_cnt_r);

  assign bus.o_ready = o_ready_r;
  assign bus.o_valid = o_valid_r;
  assign bus.o_data  = o_data_r;
  assign bus.o_last  = o_last_r;

  // Drop the common MSB once every metric has it set, so sums never wrap.
  always_comb begin
    norm_s = pm_acs_s[0][PM_W-1] & pm_acs_s[1][PM_W-1] &
             pm_acs_s[2][PM_W-1] & pm_acs_s[3][PM_W-1];
    for (int i = 0; i < 4; i++) begin
      pm_norm_s[i] = pm_acs_s[i];
      if (norm_s) begin
        pm_norm_s[i][PM_W-1] = 1'b0;
      end else begin
        pm_norm_s[i][PM_W-1] = pm_acs_s[i][PM_W-1];
      end
    end
  end

`ifdef VITERBI_TAIL_EN
  assign start_s = 2'd0;

  // Frame length and output count; the two tail bits are not emitted.
  always_comb begin
    n_s = count_r + CNT_W'(1);
    if (n_s > CNT_W'(2)) begin
      out_cnt_s = n_s - CNT_W'(2);
    end else begin
      out_cnt_s = '0;
    end
  end
`else
  // Traceback starts from the cheapest final state, lowest index on a tie.
  always_comb begin
    start_s = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm_norm_s[i] < pm_norm_s[start_s]) begin
        start_s = state_t'(i);
      end else begin
        start_s = start_s;
      end
    end
  end

  // Frame length and output count; every received symbol yields one bit.
  always_comb begin
    n_s       = count_r + CNT_W'(1);
    out_cnt_s = n_s;
  end
`endif

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_r <= RECV;
    else       state_r <= state_n;
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      RECV: begin
        if (frame_end_s) state_n = TRACE;
        else             state_n = RECV;
      end
      TRACE: begin
        if (trace_done_s) begin
          if (out_cnt_r == '0) state_n = RECV;
          else                 state_n = OUT;
        end else begin
          state_n = TRACE;
        end
      end
      OUT: begin
        if (last_hs_s) state_n = RECV;
        else           state_n = OUT;
      end
      default: state_n = RECV;
    endcase
  end

  // Metrics, counters, traceback state and registered output stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) pm_r[i] <= (i == 0) ? '0 : PM_INIT;
      count_r    <= '0;
      out_cnt_r  <= '0;
      k_r        <= '0;
      j_r        <= '0;
      tb_state_r <= 2'd0;
      o_ready_r  <= 1'b1;
      o_valid_r  <= 1'b0;
      o_data_r   <= 1'b0;
      o_last_r   <= 1'b0;
    end else begin
      o_ready_r <= (state_n == RECV);
      case (state_r)
        RECV: begin
          if (accept_s) begin
            pm_r <= pm_norm_s;
            if (frame_end_s) begin
              k_r        <= count_r[IDX_W-1:0];
              out_cnt_r  <= out_cnt_s;
              tb_state_r <= start_s;
              count_r    <= '0;
            end else begin
              count_r <= count_r + CNT_W'(1);
            end
          end
        end
        TRACE: begin
          tb_state_r <= {tb_state_r[0], surv_r[k_r][tb_state_r]};
          k_r        <= k_r - IDX_W'(1);
          if (trace_done_s) begin
            j_r <= '0;
            if (out_cnt_r == '0) begin
              for (int i = 0; i < 4; i++) pm_r[i] <= (i == 0) ? '0 : PM_INIT;
            end else begin
              o_valid_r <= 1'b1;
              o_data_r  <= tb_state_r[1];
              o_last_r  <= (out_cnt_r == CNT_W'(1));
            end
          end
        end
        OUT: begin
          if (out_hs_s) begin
            if (last_hs_s) begin
              o_valid_r <= 1'b0;
              o_data_r  <= 1'b0;
              o_last_r  <= 1'b0;
              for (int i = 0; i < 4; i++) pm_r[i] <= (i == 0) ? '0 : PM_INIT;
            end else begin
              j_r      <= j_r + IDX_W'(1);
              o_data_r <= out_buf_r[j_r + IDX_W'(1)];
              o_last_r <= ((CNT_W'(j_r) + CNT_W'(2)) == out_cnt_r);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Survivor RAM: four decision bits per accepted symbol.
  always_ff @(posedge i_clk) begin
    if (accept_s) surv_r[count_r[IDX_W-1:0]] <= dec_s;
  end

  // Output buffer filled back-to-front by the traceback.
  always_ff @(posedge i_clk) begin
    if (state_r == TRACE) out_buf_r[k_r] <= tb_state_r[1];
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: table of short frames plus
// overflow, long random frame with sparse errors, and reset during traceback.
// Expected bits come from the source bits that produced the symbols.
module tb_viterbi_decoder;

  localparam int MAX_LEN = 64;

  logic clk = 1'b0;
  logic rst;

  viterbi_decoder_if bus();

  viterbi_decoder #(.MAX_LEN(MAX_LEN), .PM_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] syms;
    int          n;
    logic [7:0]  bits;
    int          stall_at;
  } vec_t;

  typedef struct {
    bit data;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc_sym(input logic [1:0] st, input bit b);
    return {b ^ st[1] ^ st[0], b ^ st[0]};
  endfunction

  task automatic drive_frame(input logic [1:0] syms[$], input bit use_last);
    for (int i = 0; i < syms.size(); i++) begin
      check("ready_in_recv", bus.o_ready, 1);
      bus.i_valid = 1'b1;
      bus.i_data  = syms[i];
      bus.i_last  = use_last && (i == syms.size() - 1);
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_data  = 2'b00;
  endtask

  task automatic collect(input int n_sym, input int stall_at);
    int lat, j, stall, guard;
    check("ready_low_after_last", bus.o_ready, 0);
    if (sb.size() == 0) begin
      repeat (n_sym) begin
        @(posedge clk); #1;
        check("no_valid_empty_frame", bus.o_valid, 0);
      end
      check("ready_back_empty_frame", bus.o_ready, 1);
    end else begin
      lat = 0;
      while (!bus.o_valid && lat <= n_sym + 8) begin
        @(posedge clk); #1;
        lat++;
      end
      check("first_valid_latency", lat, n_sym);
      j = 0; stall = 0; guard = 0;
      while (sb.size() > 0 && bus.o_valid && guard < 4 * MAX_LEN) begin
        bus.i_ready = !(j == stall_at && stall < 3);
        if (!bus.i_ready) stall++;
        check("o_data", bus.o_data, sb[0].data);
        check("o_last", bus.o_last, sb[0].last);
        if (bus.i_ready) begin
          void'(sb.pop_front());
          j++;
        end
        @(posedge clk); #1;
        guard++;
      end
      check("outputs_missing", sb.size(), 0);
      sb.delete();
      bus.i_ready = 1'b1;
      check("valid_low_after_frame", bus.o_valid, 0);
      check("ready_high_after_frame", bus.o_ready, 1);
    end
  endtask

  task automatic run_frame(input logic [1:0] syms[$], input bit bits[$],
                           input bit use_last, input int stall_at);
    int n_exp;
`ifdef VITERBI_TAIL_EN
    n_exp = (bits.size() > 2) ? bits.size() - 2 : 0;
`else
    n_exp = bits.size();
`endif
    for (int i = 0; i < n_exp; i++) sb.push_back('{bits[i], i == n_exp - 1});
    drive_frame(syms, use_last);
    collect(syms.size(), stall_at);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[7];
    logic [1:0] syms[$];
    bit         bits[$];
    logic [1:0] st;
    logic [1:0] s;
    bit         b;

    tbl[0] = '{{4'b0, 2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11}, 6, 8'b0000_1101, -1};
    tbl[1] = '{{4'b0, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11}, 6, 8'b0000_1101, -1};
    tbl[2] = '{{4'b0, 2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11}, 6, 8'b0000_1101, 2};
    tbl[3] = '{{4'b0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11}, 6, 8'b0000_1011, -1};
    tbl[4] = '{{10'b0, 2'b11, 2'b10, 2'b11}, 3, 8'b0000_0001, -1};
    tbl[5] = '{{12'b0, 2'b10, 2'b11}, 2, 8'b0000_0001, -1};
    tbl[6] = '{{14'b0, 2'b11}, 1, 8'b0000_0001, -1};

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 2'b00;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_ready", bus.o_ready, 1);
    check("reset_o_valid", bus.o_valid, 0);
    check("reset_o_data",  bus.o_data,  0);
    check("reset_o_last",  bus.o_last,  0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of short frames: clean, single error, backpressure, length corners.
    for (int t = 0; t < 7; t++) begin
      syms.delete();
      bits.delete();
      for (int i = 0; i < tbl[t].n; i++) begin
        syms.push_back(tbl[t].syms[2*i +: 2]);
        bits.push_back(tbl[t].bits[i]);
      end
      run_frame(syms, bits, 1'b1, tbl[t].stall_at);
    end

    // Overflow: MAX_LEN zero symbols, no i_last.
    syms.delete();
    bits.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      syms.push_back(2'b00);
      bits.push_back(1'b0);
    end
    run_frame(syms, bits, 1'b0, -1);

    // Long random frame, zero-terminated, one bit error every 6 symbols.
    syms.delete();
    bits.delete();
    st = 2'b00;
    for (int i = 0; i < MAX_LEN; i++) begin
      b = (i >= MAX_LEN - 2) ? 1'b0 : 1'($urandom_range(0, 1));
      s = enc_sym(st, b);
      st = {b, st[1]};
      if ((i % 6 == 3) && (i < MAX_LEN - 10)) s = s ^ (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      syms.push_back(s);
      bits.push_back(b);
    end
    run_frame(syms, bits, 1'b1, 5);

    // Reset asserted during traceback.
    syms.delete();
    for (int i = 0; i < tbl[0].n; i++) syms.push_back(tbl[0].syms[2*i +: 2]);
    drive_frame(syms, 1'b1);
    @(posedge clk); #1;
    check("in_trace_ready_low", bus.o_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_trace_reset_valid", bus.o_valid, 0);
    check("mid_trace_reset_ready", bus.o_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean frame after the aborted one.
    syms.delete();
    bits.delete();
    for (int i = 0; i < tbl[0].n; i++) begin
      syms.push_back(tbl[0].syms[2*i +: 2]);
      bits.push_back(tbl[0].bits[i]);
    end
    run_frame(syms, bits, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
